// File: rtl/mem_port_arbiter_if.sv
// Bundle of every non-clock/reset signal of mem_port_arbiter.
//   slave  : arbiter view (takes I/D requests and memory read data, drives acks, data, strobes)
//   master : environment view (CPU core requesters plus the memory model)
// Request side : i_req/i_addr, d_req/d_we/d_addr/d_wdata
// Response side: i_ack/i_rdata, d_ack/d_rdata, err, busy
// Memory side  : mem_addr, mem_wdata, mem_we, mem_re, mem_rdata
interface mem_port_arbiter_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32
);
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_ack;
  logic [DATA_W-1:0] i_rdata;
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_ack;
  logic [DATA_W-1:0] d_rdata;
  logic              err;
  logic              busy;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic              mem_re;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output i_ack, i_rdata, d_ack, d_rdata, err, busy, mem_addr, mem_wdata, mem_we, mem_re
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  i_ack, i_rdata, d_ack, d_rdata, err, busy, mem_addr, mem_wdata, mem_we, mem_re
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port unified memory between the fetch (I) and the
// load/store (D) requesters. One access at a time: IDLE -> ACCESS (WAIT_STATES+1 cycles) -> RESP,
// with a one-cycle ack in RESP. D wins simultaneous requests.
// Ports:
//   Clk      rising-edge clock
//   Reset_n  asynchronous active-low reset; aborts any transaction in flight
//   bus      mem_port_arbiter_if.slave (requests, acks, read data, err, busy, memory strobes)
// Optional feature: define MEM_ARB_STARVE_GUARD_EN to force an I grant after STARVE_LIMIT
// consecutive D grants made while I was waiting.
module mem_port_arbiter #(
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned MEM_DEPTH    = 513,
  parameter int unsigned WAIT_STATES  = 0,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input logic               Clk,
  input logic               Reset_n,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StAccess = 2'd1,
    StResp   = 2'd2
  } state_e;

  localparam logic [ADDR_W-1:0] DepthLim = ADDR_W'(MEM_DEPTH);
  localparam logic [3:0]        WaitInit = 4'(WAIT_STATES);

  state_e            state_q, state_d;
  logic              owner_d_q;   // 1: D owns the current transaction, 0: I
  logic              we_q;
  logic              in_range_q;
  logic              err_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] i_rdata_q;
  logic [DATA_W-1:0] d_rdata_q;
  logic [3:0]        wcnt_q, wcnt_d;

  logic              grant_d, grant_i;
  logic              capture;
  logic              starve_force;
  logic              mem_re_c, mem_we_c;
  logic [ADDR_W-1:0] grant_addr;
  logic [DATA_W-1:0] cap_data;

`ifdef MEM_ARB_STARVE_GUARD_EN
  logic [3:0] scnt_q;

  assign starve_force = bus.i_req && (scnt_q == 4'(STARVE_LIMIT));

  // Only D grants that bypass a waiting fetch count; any I grant restarts the window.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      scnt_q <= 4'd0;
    end else if (grant_i) begin
      scnt_q <= 4'd0;
    end else if (grant_d && bus.i_req) begin
      scnt_q <= scnt_q + 4'd1;
    end
  end
`else
  logic unused_starve_limit;

  assign starve_force        = 1'b0;
  assign unused_starve_limit = ^STARVE_LIMIT;
`endif

  always_comb begin
    state_d  = state_q;
    wcnt_d   = wcnt_q;
    grant_d  = 1'b0;
    grant_i  = 1'b0;
    capture  = 1'b0;
    mem_re_c = 1'b0;
    mem_we_c = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (starve_force) begin
          grant_i = 1'b1;
        end else if (bus.d_req) begin
          grant_d = 1'b1;
        end else if (bus.i_req) begin
          grant_i = 1'b1;
        end
        if (grant_d || grant_i) begin
          state_d = StAccess;
          wcnt_d  = WaitInit;
        end
      end
      StAccess: begin
        // Out-of-range accesses keep their timing but never touch the memory.
        if (in_range_q) begin
          mem_re_c = !we_q;
          mem_we_c = we_q && (wcnt_q == 4'd0);  // single write edge, at the end of ACCESS
        end
        if (wcnt_q == 4'd0) begin
          capture = 1'b1;
          state_d = StResp;
        end else begin
          wcnt_d = wcnt_q - 4'd1;
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign grant_addr = grant_d ? bus.d_addr : bus.i_addr;
  assign cap_data   = (in_range_q && !we_q) ? bus.mem_rdata : '0;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q    <= StIdle;
      wcnt_q     <= 4'd0;
      owner_d_q  <= 1'b0;
      we_q       <= 1'b0;
      in_range_q <= 1'b0;
      err_q      <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      i_rdata_q  <= '0;
      d_rdata_q  <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      if (grant_d || grant_i) begin
        owner_d_q  <= grant_d;
        we_q       <= grant_d && bus.d_we;
        addr_q     <= grant_addr;
        wdata_q    <= grant_d ? bus.d_wdata : '0;
        in_range_q <= grant_addr < DepthLim;
      end
      if (capture) begin
        if (owner_d_q) begin
          d_rdata_q <= cap_data;
        end else begin
          i_rdata_q <= cap_data;
        end
        err_q <= !in_range_q;
      end
    end
  end

  // Strobes and acks decode straight from state so reset removes them at once.
  assign bus.i_ack     = (state_q == StResp) && !owner_d_q;
  assign bus.d_ack     = (state_q == StResp) && owner_d_q;
  assign bus.err       = (state_q == StResp) && err_q;
  assign bus.busy      = (state_q != StIdle);
  assign bus.i_rdata   = i_rdata_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.mem_re    = mem_re_c;
  assign bus.mem_we    = mem_we_c;

endmodule
